sync_gray_ptr_multi: RTL and testbench
======================================

// Module: sync_gray_ptr_multi
// PURPOSE
// - Parametrised successor of the 2-flop read-to-write pointer synchronizer: brings CHANNELS gray-coded
//   FIFO pointers into the wclk domain through SYNC_STAGES flops each.
// - Adds registered gray-to-binary conversion, a per-channel advance pulse, a pointer-delta output and a
//   sticky gray-coherence error flag. Sits on the write side of the multi-channel async FIFO, feeding the
//   full/almost-full logic.
// PARAMETERS
// - ADDR_WIDTH   3  FIFO address bits; each pointer is ADDR_WIDTH+1 bits (wrap bit included)
// - SYNC_STAGES  2  synchronizer depth; legal range 2..4; elaboration error outside this range
// - CHANNELS     1  number of independent pointers; legal range 1..8
// PORTS  (P = ADDR_WIDTH+1)
// - wclk          in   1           destination clock; all flops on rising edge
// - wrst          in   1           synchronous reset, active-high
// - rptr          in   CHANNELS*P  gray pointers from the source domain; channel c = rptr[c*P +: P]
// - err_clr       in   CHANNELS    per-channel clear of gray_err; synchronous, wclk domain
// - wq_rptr       out  CHANNELS*P  synchronized gray pointers, last stage of each chain
// - wq_rptr_bin   out  CHANNELS*P  binary of wq_rptr, registered
// - ptr_adv       out  CHANNELS    1-cycle pulse: synced pointer changed vs previous cycle
// - ptr_delta     out  CHANNELS*P  (bin_new - bin_prev) mod 2^P, registered; 0 when no change
// - gray_err      out  CHANNELS    sticky: successive synced samples differed in more than one bit
// BEHAVIOUR
// - Reset: wrst high at an edge zeroes all sync stages, wq_rptr, wq_rptr_bin, ptr_delta, ptr_adv,
//   gray_err and the internal previous-sample register. No pulses or errors on the first cycles after
//   reset release while the chains still hold zero.
// - Reset mid-operation takes effect at the next edge and overrides every other update, err_clr included.
// - Sync chain: stage0 <= rptr; stage[i] <= stage[i-1]; wq_rptr = stage[SYNC_STAGES-1].
//   A value stable on rptr at edge k appears on wq_rptr after edge k+SYNC_STAGES-1, i.e. latency
//   SYNC_STAGES cycles.
// - Post stage, per channel, one further cycle (latency SYNC_STAGES+1):
//   - prev <= wq_rptr
//   - wq_rptr_bin <= gray2bin(wq_rptr)
//   - ptr_adv <= (wq_rptr != prev)
//   - ptr_delta <= gray2bin(wq_rptr) - gray2bin(prev), truncated to P bits
//     (wrap-around is naturally modulo 2^P)
// - Coherence: if popcount(wq_rptr ^ prev) > 1, set gray_err[c] in the same cycle as ptr_adv.
//   The update is still applied; the error is reported, not filtered.
// - gray_err: cleared by err_clr[c]; a set event in the same cycle as err_clr wins and the flag stays 1.
// - Channels are fully independent; no cross-channel state.
// - No handshake on rptr. The source must change rptr by at most one gray step per source-clock cycle.
// STRUCTURE
// - Package sync_ptr_pkg holds:
//   - function gray2bin(P-bit)
//   - function popcount_gt1
//   - localparams for the legal SYNC_STAGES/CHANNELS bounds
// - Sub-module sync_stage_chain (WIDTH, STAGES): plain shift-register synchronizer with synchronous
//   active-high reset. Instantiated once per channel in a generate loop; the post stage lives in the top.
// TESTING
// - Reset: drive rptr=4'b0110 for all channels with wrst high for 3 cycles ->
//   all outputs 0 during reset; ptr_adv stays 0 on the first post-reset cycles.
// - Latency (SYNC_STAGES=2, ADDR_WIDTH=3): rptr 0000->0001 at edge k ->
//   wq_rptr=0001 after edge k+1; wq_rptr_bin=1, ptr_adv=1, ptr_delta=1 after edge k+2; ptr_adv=0 one cycle later.
// - Wrap: step the gray sequence 0..15 then back to 0 (gray 1000->0000) ->
//   16 ptr_adv pulses, every ptr_delta=1 including the wrap step, gray_err stays 0.
// - Coherence error: jump rptr 0000->0011 ->
//   gray_err=1 with ptr_adv=1 and ptr_delta=2; gray_err holds until err_clr.
//   err_clr together with a new 2-bit jump -> gray_err stays 1.
// - Multi-channel (CHANNELS=4, SYNC_STAGES=3): step channel 2 only ->
//   ptr_adv=4'b0100 exactly SYNC_STAGES+1 cycles after the change; other channels unchanged.
// - Reset mid-stream: assert wrst while a change is in flight in the chain ->
//   next edge all outputs 0; the in-flight value is lost; no ptr_adv after release unless rptr is nonzero.

Source files
------------

// File: rtl/sync_ptr_pkg.sv
// sync_ptr_pkg: gray-pointer helpers and legal parameter bounds for the pointer synchronizer
package sync_ptr_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CHANNELS_MIN    = 1;
  localparam int CHANNELS_MAX    = 8;
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
  function automatic logic popcount_gt1(input logic [31:0] x);
    return (x & (x - 32'd1)) != 32'd0;
  endfunction
endpackage

// File: rtl/sync_stage_chain.sv
// sync_stage_chain: plain shift-register synchronizer with synchronous active-high reset
module sync_stage_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  always_comb stage_d = {stage_q[STAGES-2:0], d};
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end
  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/sync_gray_ptr_multi.sv
// sync_gray_ptr_multi: multi-channel gray pointer synchronizer with binary, advance, delta and coherence outputs
module sync_gray_ptr_multi
  import sync_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CHANNELS    = 1
) (
  input  logic                             wclk,
  input  logic                             wrst,
  input  logic [CHANNELS*(ADDR_WIDTH+1)-1:0] rptr,
  input  logic [CHANNELS-1:0]              err_clr,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] wq_rptr,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] wq_rptr_bin,
  output logic [CHANNELS-1:0]              ptr_adv,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] ptr_delta,
  output logic [CHANNELS-1:0]              gray_err
);
  localparam int P = ADDR_WIDTH + 1;
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_gray_ptr_multi: SYNC_STAGES out of range 2..4");
  end
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("sync_gray_ptr_multi: CHANNELS out of range 1..8");
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [P-1:0] cur, prev_q, prev_d, bin_q, bin_d, delta_q, delta_d;
    logic         adv_q, adv_d, err_q, err_d;
    sync_stage_chain #(.WIDTH(P), .STAGES(SYNC_STAGES)) u_chain (
      .clk(wclk),
      .rst(wrst),
      .d  (rptr[c*P +: P]),
      .q  (cur)
    );
    // a multi-bit jump is still passed through; the error flag only reports it
    always_comb begin
      prev_d  = cur;
      bin_d   = P'(gray2bin(32'(cur)));
      adv_d   = cur != prev_q;
      delta_d = bin_d - P'(gray2bin(32'(prev_q)));
      err_d   = popcount_gt1(32'(cur ^ prev_q)) | (err_q & ~err_clr[c]);
    end
    always_ff @(posedge wclk) begin
      if (wrst) begin
        prev_q  <= '0;
        bin_q   <= '0;
        delta_q <= '0;
        adv_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        prev_q  <= prev_d;
        bin_q   <= bin_d;
        delta_q <= delta_d;
        adv_q   <= adv_d;
        err_q   <= err_d;
      end
    end
    assign wq_rptr[c*P +: P]     = cur;
    assign wq_rptr_bin[c*P +: P] = bin_q;
    assign ptr_delta[c*P +: P]   = delta_q;
    assign ptr_adv[c]            = adv_q;
    assign gray_err[c]           = err_q;
  end
endmodule

// File: tb/tb_sync_gray_ptr_multi.sv
// tb_sync_gray_ptr_multi: randomized and directed checks against a sample-history reference model
module tb_sync_gray_ptr_multi;
  localparam int AW = 3;
  localparam int S  = 3;
  localparam int CH = 4;
  localparam int P  = AW + 1;
  localparam int W  = CH * P;
  logic          clk = 1'b0;
  logic          wrst = 1'b1;
  logic [W-1:0]  rptr = '0;
  logic [CH-1:0] err_clr = '0;
  logic [W-1:0]  wq_rptr, wq_rptr_bin, ptr_delta;
  logic [CH-1:0] ptr_adv, gray_err;
  logic [W-1:0]  hist [S+2];
  logic [CH-1:0] m_err;
  logic [W-1:0]  exp_wq, exp_bin, exp_delta;
  logic [CH-1:0] exp_adv, exp_err;
  int tests = 0;
  int fails = 0;
  sync_gray_ptr_multi #(.ADDR_WIDTH(AW), .SYNC_STAGES(S), .CHANNELS(CH)) dut (
    .wclk(clk), .wrst(wrst), .rptr(rptr), .err_clr(err_clr),
    .wq_rptr(wq_rptr), .wq_rptr_bin(wq_rptr_bin), .ptr_adv(ptr_adv),
    .ptr_delta(ptr_delta), .gray_err(gray_err)
  );
  always #5 clk = ~clk;
  function automatic logic [P-1:0] gray(input int i);
    return P'((i % 16) ^ ((i % 16) >> 1));
  endfunction
  function automatic int to_bin(input logic [P-1:0] g);
    for (int i = 0; i < 16; i++) if (gray(i) == g) return i;
    return 0;
  endfunction
  // history[0] is the rptr sampled at the latest edge; a reset edge wipes every sample in flight
  task automatic step(input logic [W-1:0] r, input logic [CH-1:0] clr, input logic rs);
    logic [P-1:0] cur, pv;
    rptr = r; err_clr = clr; wrst = rs;
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < S+2; i++) hist[i] = '0;
      m_err = '0;
    end else begin
      for (int i = S+1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = r;
    end
    exp_wq = hist[S-1];
    for (int c = 0; c < CH; c++) begin
      cur = hist[S][c*P +: P];
      pv  = hist[S+1][c*P +: P];
      if (!rs) m_err[c] = ($countones(cur ^ pv) > 1) || (m_err[c] && !clr[c]);
      exp_bin[c*P +: P]   = P'(to_bin(cur));
      exp_adv[c]          = cur != pv;
      exp_delta[c*P +: P] = P'((to_bin(cur) - to_bin(pv) + 16) % 16);
    end
    exp_err = m_err;
    #1;
  endtask
  task automatic reinit();
    step('0, '0, 1'b1);
    for (int i = 0; i < S+2; i++) step('0, '0, 1'b0);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step({CH{4'b0110}}, '0, 1'b1);
      tests++;
      if ({wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err} !== '0) begin
        fails++;
        $display("FAIL reset_zero cyc=%0d got wq=%h bin=%h adv=%b delta=%h err=%b want all 0",
                 i, wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err);
      end
    end
    for (int i = 0; i < S+3; i++) begin
      step({CH{4'b0110}}, '0, 1'b0);
      tests++;
      if (i < S && ptr_adv !== '0) begin
        fails++;
        $display("FAIL reset_release_adv cyc=%0d got %b want 0", i, ptr_adv);
      end
      tests++;
      if ({wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err} !== {exp_wq, exp_bin, exp_adv, exp_delta, exp_err}) begin
        fails++;
        $display("FAIL reset_model cyc=%0d got %h/%h/%b/%h/%b want %h/%h/%b/%h/%b", i,
                 wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err, exp_wq, exp_bin, exp_adv, exp_delta, exp_err);
      end
    end
  endtask
  task automatic test_latency();
    logic [W-1:0] r;
    reinit();
    r = '0;
    r[3:0] = 4'b0001;
    for (int n = 0; n <= S+1; n++) begin
      step(r, '0, 1'b0);
      tests++;
      if (wq_rptr[3:0] !== ((n >= S-1) ? 4'b0001 : 4'b0000)) begin
        fails++;
        $display("FAIL latency_wq n=%0d got %b want %b", n, wq_rptr[3:0], (n >= S-1) ? 4'b0001 : 4'b0000);
      end
      if (n == S) begin
        tests++;
        if ({ptr_adv[0], wq_rptr_bin[3:0], ptr_delta[3:0]} !== {1'b1, 4'd1, 4'd1}) begin
          fails++;
          $display("FAIL latency_post got adv=%b bin=%0d delta=%0d want adv=1 bin=1 delta=1",
                   ptr_adv[0], wq_rptr_bin[3:0], ptr_delta[3:0]);
        end
      end
      if (n == S+1) begin
        tests++;
        if (ptr_adv[0] !== 1'b0) begin
          fails++;
          $display("FAIL latency_pulse_end got adv=%b want 0", ptr_adv[0]);
        end
      end
    end
  endtask
  task automatic test_wrap();
    logic [W-1:0] r;
    int cnt;
    reinit();
    r = '0;
    cnt = 0;
    for (int i = 1; i <= 16 + S + 2; i++) begin
      if (i <= 16) r[7:4] = gray(i);
      step(r, '0, 1'b0);
      if (ptr_adv[1]) begin
        cnt++;
        tests++;
        if (ptr_delta[7:4] !== 4'd1) begin
          fails++;
          $display("FAIL wrap_delta step=%0d got %0d want 1", i, ptr_delta[7:4]);
        end
      end
      tests++;
      if ({wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err} !== {exp_wq, exp_bin, exp_adv, exp_delta, exp_err}) begin
        fails++;
        $display("FAIL wrap_model step=%0d got %h/%h/%b/%h/%b want %h/%h/%b/%h/%b", i,
                 wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err, exp_wq, exp_bin, exp_adv, exp_delta, exp_err);
      end
    end
    tests++;
    if (cnt !== 16 || gray_err[1] !== 1'b0) begin
      fails++;
      $display("FAIL wrap_count got pulses=%0d err=%b want pulses=16 err=0", cnt, gray_err[1]);
    end
  endtask
  task automatic test_coherence();
    logic [W-1:0] r;
    reinit();
    r = '0;
    r[3:0] = 4'b0011;
    for (int n = 0; n <= S+3; n++) begin
      step(r, '0, 1'b0);
      if (n == S) begin
        tests++;
        if ({gray_err[0], ptr_adv[0], ptr_delta[3:0]} !== {1'b1, 1'b1, 4'd2}) begin
          fails++;
          $display("FAIL coh_set got err=%b adv=%b delta=%0d want err=1 adv=1 delta=2",
                   gray_err[0], ptr_adv[0], ptr_delta[3:0]);
        end
      end
    end
    tests++;
    if (gray_err[0] !== 1'b1) begin
      fails++;
      $display("FAIL coh_hold got %b want 1", gray_err[0]);
    end
    step(r, 4'b0001, 1'b0);
    tests++;
    if (gray_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL coh_clear got %b want 0", gray_err[0]);
    end
    r[3:0] = 4'b0000;
    for (int n = 0; n <= S+1; n++) begin
      step(r, (n == S) ? 4'b0001 : 4'b0000, 1'b0);
      tests++;
      if ({wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err} !== {exp_wq, exp_bin, exp_adv, exp_delta, exp_err}) begin
        fails++;
        $display("FAIL coh_model n=%0d got %h/%h/%b/%h/%b want %h/%h/%b/%h/%b", n,
                 wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err, exp_wq, exp_bin, exp_adv, exp_delta, exp_err);
      end
    end
    tests++;
    if (gray_err[0] !== 1'b1) begin
      fails++;
      $display("FAIL coh_set_beats_clr got %b want 1", gray_err[0]);
    end
  endtask
  task automatic test_multi();
    logic [W-1:0] r;
    reinit();
    r = '0;
    r[11:8] = 4'b0001;
    for (int n = 0; n <= S+1; n++) begin
      step(r, '0, 1'b0);
      tests++;
      if (ptr_adv !== ((n == S) ? 4'b0100 : 4'b0000) || {wq_rptr[15:12], wq_rptr[7:0]} !== '0) begin
        fails++;
        $display("FAIL multi_ch2 n=%0d got adv=%b wq=%h want adv=%b others 0",
                 n, ptr_adv, wq_rptr, (n == S) ? 4'b0100 : 4'b0000);
      end
    end
  endtask
  task automatic test_random();
    logic [W-1:0] r;
    logic [CH-1:0] clr;
    int idx [CH];
    reinit();
    r = '0;
    for (int c = 0; c < CH; c++) idx[c] = 0;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(2) == 0) idx[c] = (idx[c] + 1) % 16;
        r[c*P +: P] = gray(idx[c]);
        if ($urandom_range(24) == 0) r[c*P +: P] = P'($urandom);
        clr[c] = $urandom_range(7) == 0;
      end
      step(r, clr, $urandom_range(99) == 0);
      tests++;
      if ({wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err} !== {exp_wq, exp_bin, exp_adv, exp_delta, exp_err}) begin
        fails++;
        $display("FAIL random_model cyc=%0d got %h/%h/%b/%h/%b want %h/%h/%b/%h/%b", i,
                 wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err, exp_wq, exp_bin, exp_adv, exp_delta, exp_err);
      end
    end
  endtask
  task automatic test_midreset();
    reinit();
    step({CH{gray(3)}}, '0, 1'b0);
    step({CH{gray(3)}}, '0, 1'b0);
    step('0, '0, 1'b1);
    tests++;
    if ({wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err} !== '0) begin
      fails++;
      $display("FAIL midreset_zero got wq=%h bin=%h adv=%b delta=%h err=%b want all 0",
               wq_rptr, wq_rptr_bin, ptr_adv, ptr_delta, gray_err);
    end
    for (int n = 0; n < S+3; n++) begin
      step('0, '0, 1'b0);
      tests++;
      if (ptr_adv !== '0 || wq_rptr !== '0) begin
        fails++;
        $display("FAIL midreset_lost n=%0d got adv=%b wq=%h want 0", n, ptr_adv, wq_rptr);
      end
    end
  endtask
  initial begin
    m_err = '0;
    for (int i = 0; i < S+2; i++) hist[i] = '0;
    test_reset();
    test_latency();
    test_wrap();
    test_coherence();
    test_multi();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
